life_cursor_control: RTL and testbench



---
 rtl/life_cursor_control_if.sv | 28 ++
 rtl/life_cursor_control.sv | 183 ++++++++++++++++++
 tb/tb_life_cursor_control.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/life_cursor_control_if.sv
// Cursor controller bus: debounced controls in, cursor position and
// cell-toggle handshake out.
interface life_cursor_control_if #(
  parameter int unsigned X_BITS = 5,
  parameter int unsigned Y_BITS = 5
);
  logic [3:0]        button;          // {left, right, up, down}
  logic              toggle;
  logic              toggle_ack;
  logic [X_BITS-1:0] cursor_x;
  logic [Y_BITS-1:0] cursor_y;
  logic              toggle_req;
  logic [X_BITS-1:0] toggle_x;
  logic [Y_BITS-1:0] toggle_y;
  logic              cursor_visible;

  // Upstream/downstream side that drives the controls and consumes the outputs
  modport master (
    output button, toggle, toggle_ack,
    input  cursor_x, cursor_y, toggle_req, toggle_x, toggle_y, cursor_visible
  );

  // Cursor controller side
  modport slave (
    input  button, toggle, toggle_ack,
    output cursor_x, cursor_y, toggle_req, toggle_x, toggle_y, cursor_visible
  );
endinterface

// File: rtl/life_cursor_control.sv
// Edit-cursor controller for the Life board: wrapping cursor with
// auto-repeat, and one-at-a-time cell-toggle requests over req/ack.
// Optional cursor blink: define LIFE_CURSOR_BLINK_EN.
module life_cursor_control #(
  parameter int unsigned GRID_W       = 32,
  parameter int unsigned GRID_H       = 24,
  parameter int unsigned X_BITS       = 5,
  parameter int unsigned Y_BITS       = 5,
  parameter int unsigned REPEAT_DELAY = 4,
  parameter int unsigned REPEAT_RATE  = 1
`ifdef LIFE_CURSOR_BLINK_EN
  ,
  parameter int unsigned BLINK_PERIOD = 2
`endif
) (
  input logic                  clock,
  input logic                  reset,
  life_cursor_control_if.slave bus
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {REQ_IDLE, REQ_PEND} req_state_e;

  req_state_e        state_q, state_d;
  logic [X_BITS-1:0] cursor_x_q, cursor_x_d;
  logic [Y_BITS-1:0] cursor_y_q, cursor_y_d;
  logic [X_BITS-1:0] toggle_x_q, toggle_x_d;
  logic [Y_BITS-1:0] toggle_y_q, toggle_y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        dir_prev_q, dir_prev_d;
  logic              tog_prev_q, tog_prev_d;
  logic              armed_q, armed_d;

  logic [3:0] dir;
  logic       step;
  logic       tog_rise;

  function automatic logic [X_BITS-1:0] x_inc(input logic [X_BITS-1:0] x);
    return (x == X_BITS'(GRID_W - 1)) ? '0 : X_BITS'(x + X_BITS'(1));
  endfunction

  function automatic logic [X_BITS-1:0] x_dec(input logic [X_BITS-1:0] x);
    return (x == '0) ? X_BITS'(GRID_W - 1) : X_BITS'(x - X_BITS'(1));
  endfunction

  function automatic logic [Y_BITS-1:0] y_inc(input logic [Y_BITS-1:0] y);
    return (y == Y_BITS'(GRID_H - 1)) ? '0 : Y_BITS'(y + Y_BITS'(1));
  endfunction

  function automatic logic [Y_BITS-1:0] y_dec(input logic [Y_BITS-1:0] y);
    return (y == '0) ? Y_BITS'(GRID_H - 1) : Y_BITS'(y - Y_BITS'(1));
  endfunction

  // Direction decode {x+, x-, y+, y-}; opposing buttons cancel per axis
  always_comb begin
    dir = {bus.button[2] & ~bus.button[3],
           bus.button[3] & ~bus.button[2],
           bus.button[0] & ~bus.button[1],
           bus.button[1] & ~bus.button[0]};
  end

  // Step timing (first press, repeat delay, repeat rate) and cursor update
  always_comb begin
    step       = 1'b0;
    cnt_d      = '0;
    dir_prev_d = dir;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    if (dir != 4'b0000) begin
      if (dir != dir_prev_q) begin
        step  = 1'b1;
        cnt_d = CNT_W'(REPEAT_DELAY - 1);
      end else if (cnt_q == '0) begin
        step  = 1'b1;
        cnt_d = CNT_W'(REPEAT_RATE - 1);
      end else begin
        cnt_d = CNT_W'(cnt_q - CNT_W'(1));
      end
    end
    if (step) begin
      if (dir[3]) cursor_x_d = x_inc(cursor_x_q);
      if (dir[2]) cursor_x_d = x_dec(cursor_x_q);
      if (dir[1]) cursor_y_d = y_inc(cursor_y_q);
      if (dir[0]) cursor_y_d = y_dec(cursor_y_q);
    end
  end

  // Toggle edge detect; a switch held through reset must go low before it can request
  always_comb begin
    tog_prev_d = bus.toggle;
    armed_d    = armed_q | ~bus.toggle;
    tog_rise   = bus.toggle & ~tog_prev_q & armed_q;
  end

  // Request handshake: latch pre-step cursor on an edge, hold until ack
  always_comb begin
    state_d    = state_q;
    toggle_x_d = toggle_x_q;
    toggle_y_d = toggle_y_q;
    unique case (state_q)
      REQ_IDLE: begin
        if (tog_rise) begin
          state_d    = REQ_PEND;
          toggle_x_d = cursor_x_q;
          toggle_y_d = cursor_y_q;
        end
      end
      REQ_PEND: begin
        if (bus.toggle_ack) state_d = REQ_IDLE;
      end
      default: state_d = REQ_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= REQ_IDLE;
      cursor_x_q <= X_BITS'(GRID_W / 2);
      cursor_y_q <= Y_BITS'(GRID_H / 2);
      toggle_x_q <= '0;
      toggle_y_q <= '0;
      cnt_q      <= '0;
      dir_prev_q <= '0;
      tog_prev_q <= 1'b0;
      armed_q    <= ~bus.toggle;
    end else begin
      state_q    <= state_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      toggle_x_q <= toggle_x_d;
      toggle_y_q <= toggle_y_d;
      cnt_q      <= cnt_d;
      dir_prev_q <= dir_prev_d;
      tog_prev_q <= tog_prev_d;
      armed_q    <= armed_d;
    end
  end

`ifdef LIFE_CURSOR_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_PERIOD + 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               visible_q, visible_d;

  // Free-running blink; any step shows the cursor and restarts the period
  always_comb begin
    blink_cnt_d = BLINK_W'(blink_cnt_q + BLINK_W'(1));
    visible_d   = visible_q;
    if (step) begin
      blink_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_PERIOD - 1)) begin
      blink_cnt_d = '0;
      visible_d   = ~visible_q;
    end
  end

  // Blink registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt_q <= '0;
      visible_q   <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      visible_q   <= visible_d;
    end
  end

  assign bus.cursor_visible = visible_q;
`else
  assign bus.cursor_visible = 1'b1;
`endif

  assign bus.cursor_x   = cursor_x_q;
  assign bus.cursor_y   = cursor_y_q;
  assign bus.toggle_req = (state_q == REQ_PEND);
  assign bus.toggle_x   = toggle_x_q;
  assign bus.toggle_y   = toggle_y_q;

endmodule

// File: tb/tb_life_cursor_control.sv
// Directed bench for life_cursor_control (default build, no blink).
module tb_life_cursor_control;

  typedef struct packed {
    logic [4:0] cx;
    logic [4:0] cy;
    logic       req;
    logic [4:0] tx;
    logic [4:0] ty;
    logic       vis;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  life_cursor_control_if #(.X_BITS(5), .Y_BITS(5)) bus ();

  life_cursor_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input int cx, input int cy, input logic req,
                              input int tx, input int ty);
    exp_t e;
    e.cx  = 5'(cx);
    e.cy  = 5'(cy);
    e.req = req;
    e.tx  = 5'(tx);
    e.ty  = 5'(ty);
    e.vis = 1'b1;
    return e;
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check
  task automatic tick(input logic [3:0] b, input logic t, input logic a, input logic r,
                      input exp_t e, input string tag);
    exp_t  want;
    exp_t  got;
    string name;
    bus.button     = b;
    bus.toggle     = t;
    bus.toggle_ack = a;
    reset          = r;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    want = exp_q.pop_front();
    name = tag_q.pop_front();
    got  = {bus.cursor_x, bus.cursor_y, bus.toggle_req, bus.toggle_x, bus.toggle_y,
            bus.cursor_visible};
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed cur=(%0d,%0d) req=%b tgt=(%0d,%0d) vis=%b expected cur=(%0d,%0d) req=%b tgt=(%0d,%0d) vis=%b",
             name, got.cx, got.cy, got.req, got.tx, got.ty, got.vis,
             want.cx, want.cy, want.req, want.tx, want.ty, want.vis);
    end
  endtask

  initial begin
    int rx [7] = '{17, 17, 17, 17, 18, 19, 20};

    bus.button     = 4'b0000;
    bus.toggle     = 1'b0;
    bus.toggle_ack = 1'b0;
    reset          = 1'b1;

    // Reset state
    tick(4'b0000, 0, 0, 1, mk(16, 12, 0, 0, 0), "rst0");
    tick(4'b0000, 0, 0, 1, mk(16, 12, 0, 0, 0), "rst1");
    tick(4'b0000, 0, 1, 0, mk(16, 12, 0, 0, 0), "ack_idle");

    // Right held: first step, repeat delay, repeat rate
    for (int i = 0; i < 7; i++)
      tick(4'b0100, 0, 0, 0, mk(rx[i], 12, 0, 0, 0), "repeat");
    tick(4'b0000, 0, 0, 0, mk(20, 12, 0, 0, 0), "release0");
    tick(4'b0000, 0, 0, 0, mk(20, 12, 0, 0, 0), "release1");

    // Opposing buttons cancel
    tick(4'b1100, 0, 0, 0, mk(20, 12, 0, 0, 0), "cancel_lr");
    tick(4'b0000, 0, 0, 0, mk(20, 12, 0, 0, 0), "cancel_rel");
    tick(4'b1110, 0, 0, 0, mk(20, 11, 0, 0, 0), "cancel_lru");
    tick(4'b0000, 0, 0, 0, mk(20, 11, 0, 0, 0), "cancel_rel2");

    // Walk to (0,0) with single taps
    for (int i = 0; i < 20; i++) begin
      tick(4'b1000, 0, 0, 0, mk(19 - i, 11, 0, 0, 0), "tap_left");
      tick(4'b0000, 0, 0, 0, mk(19 - i, 11, 0, 0, 0), "tap_rel");
    end
    for (int i = 0; i < 11; i++) begin
      tick(4'b0010, 0, 0, 0, mk(0, 10 - i, 0, 0, 0), "tap_up");
      tick(4'b0000, 0, 0, 0, mk(0, 10 - i, 0, 0, 0), "tap_rel");
    end

    // Wrap boundaries
    tick(4'b1000, 0, 0, 0, mk(31, 0, 0, 0, 0), "wrap_left");
    tick(4'b0000, 0, 0, 0, mk(31, 0, 0, 0, 0), "wrap_rel");
    tick(4'b0010, 0, 0, 0, mk(31, 23, 0, 0, 0), "wrap_up");
    tick(4'b0000, 0, 0, 0, mk(31, 23, 0, 0, 0), "wrap_rel");
    tick(4'b0101, 0, 0, 0, mk(0, 0, 0, 0, 0), "wrap_rd");
    tick(4'b0000, 0, 0, 0, mk(0, 0, 0, 0, 0), "wrap_rel");

    // Walk to (5,7)
    for (int i = 0; i < 5; i++) begin
      tick(4'b0100, 0, 0, 0, mk(i + 1, 0, 0, 0, 0), "tap_right");
      tick(4'b0000, 0, 0, 0, mk(i + 1, 0, 0, 0, 0), "tap_rel");
    end
    for (int i = 0; i < 7; i++) begin
      tick(4'b0001, 0, 0, 0, mk(5, i + 1, 0, 0, 0), "tap_down");
      tick(4'b0000, 0, 0, 0, mk(5, i + 1, 0, 0, 0), "tap_rel");
    end

    // Handshake: latch, move while pending, dropped edges, ack
    tick(4'b0000, 1, 0, 0, mk(5, 7, 1, 5, 7), "treq");
    tick(4'b0100, 1, 0, 0, mk(6, 7, 1, 5, 7), "move_pend0");
    tick(4'b0000, 1, 0, 0, mk(6, 7, 1, 5, 7), "move_rel0");
    tick(4'b0100, 1, 0, 0, mk(7, 7, 1, 5, 7), "move_pend1");
    tick(4'b0000, 1, 0, 0, mk(7, 7, 1, 5, 7), "move_rel1");
    tick(4'b0000, 0, 0, 0, mk(7, 7, 1, 5, 7), "tog_low");
    tick(4'b0000, 1, 0, 0, mk(7, 7, 1, 5, 7), "drop_edge");
    tick(4'b0000, 0, 0, 0, mk(7, 7, 1, 5, 7), "tog_low2");
    tick(4'b0000, 1, 1, 0, mk(7, 7, 0, 5, 7), "ack_drop_edge");
    tick(4'b0000, 1, 0, 0, mk(7, 7, 0, 5, 7), "no_queued");
    tick(4'b0000, 0, 0, 0, mk(7, 7, 0, 5, 7), "tog_low3");
    tick(4'b0100, 1, 0, 0, mk(8, 7, 1, 7, 7), "treq_with_step");
    tick(4'b0000, 1, 1, 0, mk(8, 7, 0, 7, 7), "ack2");

    // Reset mid-request with the switch held high
    tick(4'b0000, 0, 0, 0, mk(8, 7, 0, 7, 7), "tog_low4");
    tick(4'b0000, 1, 0, 0, mk(8, 7, 1, 8, 7), "treq3");
    tick(4'b0000, 1, 0, 1, mk(16, 12, 0, 0, 0), "rst_mid0");
    tick(4'b0000, 1, 0, 1, mk(16, 12, 0, 0, 0), "rst_mid1");
    tick(4'b0000, 1, 0, 0, mk(16, 12, 0, 0, 0), "held_no_req0");
    tick(4'b0000, 1, 0, 0, mk(16, 12, 0, 0, 0), "held_no_req1");
    tick(4'b0000, 0, 0, 0, mk(16, 12, 0, 0, 0), "post_rst_low");
    tick(4'b0000, 1, 0, 0, mk(16, 12, 1, 16, 12), "post_rst_req");
    tick(4'b0000, 1, 1, 0, mk(16, 12, 0, 16, 12), "post_rst_ack");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
